// File: rtl/arr_serializer_pkg.sv
// arr_ser_pkg
//   Shared types and helpers for the array serializer and related stream
//   blocks.
//   - ser_state_t : two-state control FSM encoding (IDLE / SEND).
//   - idx_w(n)    : index width needed to address n elements, never below 1.
package arr_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A one-element array still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/arr_serializer_mod_counter.sv
// mod_counter
//   Modulo counter that counts 0..MAX and wraps to 0 on the step taken at
//   MAX. Intended for element indices in stream blocks.
//   Ports:
//     clk  in   clock
//     rst  in   synchronous active-high reset, count <= 0
//     en   in   advance the count by one (wrapping at MAX)
//     clr  in   force the count to 0; wins over en
//     cnt  out  current count, W bits
//     last out  count is at its terminal value MAX
module mod_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      // Wrap explicitly at MAX so non-power-of-two ranges never overrun.
      if (last) cnt <= '0;
      else      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/arr_serializer.sv
// arr_serializer
//   Captures a parallel array of N = WIDTH*HEIGHT words in one cycle and
//   drains it as a stream, one word per cycle, in index order 0..N-1.
//   Valid/ready on both sides; a new array can be captured on the same edge
//   as the last element of the previous one, so back-to-back arrays stream
//   without a bubble.
//   Ports:
//     clk       in   clock
//     rst       in   synchronous active-high reset
//     in_valid  in   parallel array on in_data is valid
//     in_ready  out  an array can be captured this cycle
//     in_data   in   unpacked parallel array, N words of BW bits
//     out_valid out  out_data holds a valid element
//     out_ready in   downstream accepts the element
//     out_data  out  current element
//     out_idx   out  index of the current element
//     out_last  out  current element is index N-1
//     busy      out  high while an array is being sent
module arr_serializer
  import arr_ser_pkg::*;
#(
  parameter  int BW     = 10,
  parameter  int WIDTH  = 1,
  parameter  int HEIGHT = 1,
  localparam int N      = WIDTH * HEIGHT,
  localparam int IW     = idx_w(WIDTH * HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data [N-1:0],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy
);

  ser_state_t    state, state_nxt;
  logic [BW-1:0] data_buf [N-1:0];
  logic [IW-1:0] idx;
  logic          idx_last;
  logic          capture;
  logic          xfer;

  // Handshake decode. in_ready depends only on registered state and
  // out_ready, never on in_valid, so upstream sees no combinational loop.
  always_comb begin
    in_ready = 1'b0;
    xfer     = 1'b0;
    if (state == IDLE) begin
      in_ready = 1'b1;
    end else begin
      xfer     = out_ready;
      in_ready = idx_last && out_ready;
    end
  end

  assign capture = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and registered-state decoded outputs
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = idx_last;
        busy      = 1'b1;
        // A final transfer with a new array waiting stays in SEND.
        if (xfer && idx_last && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Element index. clr on capture restarts at 0; the final transfer also
  // wraps to 0 through the counter's own terminal count.
  mod_counter #(
    .MAX (N - 1),
    .W   (IW)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .en   (xfer),
    .clr  (capture),
    .cnt  (idx),
    .last (idx_last)
  );

  // Array buffer: whole array captured in one edge, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) data_buf[k] <= '0;
    end else if (capture) begin
      data_buf <= in_data;
    end
  end

  assign out_data = data_buf[idx];
  assign out_idx  = idx;

endmodule

// File: tb/tb_arr_serializer.sv
// tb_arr_serializer
//   Scoreboard bench for arr_serializer. Two instances: a 2x2 array of
//   10-bit words and a 1x1 array of 4-bit words. Stimulus pushes the
//   expected element stream; per-instance monitors pop and compare on every
//   transfer. Directed checks cover reset state, stalls, in_ready timing
//   and bubble-free back-to-back streaming.
module tb_arr_serializer;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  exp_t q4[$];
  exp_t q1[$];

  // 2x2 instance
  logic       rst4, in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4;
  logic [9:0] in4 [3:0];
  logic [9:0] out_data4;
  logic [1:0] out_idx4;

  // 1x1 instance
  logic       rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [3:0] in1 [0:0];
  logic [3:0] out_data1;
  logic [0:0] out_idx1;

  arr_serializer #(.BW(10), .WIDTH(2), .HEIGHT(2)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_idx(out_idx4), .out_last(out_last4), .busy(busy4)
  );

  arr_serializer #(.BW(4), .WIDTH(1), .HEIGHT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    in4[0] = 10'(a); in4[1] = 10'(b); in4[2] = 10'(c); in4[3] = 10'(d);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    q4.push_back('{data: a, idx: 0, last: 1'b0});
    q4.push_back('{data: b, idx: 1, last: 1'b0});
    q4.push_back('{data: c, idx: 2, last: 1'b0});
    q4.push_back('{data: d, idx: 3, last: 1'b1});
  endtask

  // Monitors: a transfer is out_valid && out_ready outside reset.
  always @(negedge clk) begin
    if (!rst4 && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        check("n4_unexpected_xfer", int'(out_data4), -1);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("n4_data", int'(out_data4), e.data);
        check("n4_idx",  int'(out_idx4),  e.idx);
        check("n4_last", int'(out_last4), int'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        check("n1_unexpected_xfer", int'(out_data1), -1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("n1_data", int'(out_data1), e.data);
        check("n1_idx",  int'(out_idx1),  e.idx);
        check("n1_last", int'(out_last1), int'(e.last));
      end
    end
  end

  initial begin
    rst4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b0; load4(0, 0, 0, 0);
    rst1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0; in1[0] = 4'd0;
    cyc(2);

    // Reset state
    check("rst_out_valid", int'(out_valid4), 0);
    check("rst_out_idx",   int'(out_idx4),   0);
    check("rst_out_data",  int'(out_data4),  0);
    check("rst_out_last",  int'(out_last4),  0);
    check("rst_busy",      int'(busy4),      0);
    rst4 = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready4), 1);

    // Basic drain
    load4(3, 7, 11, 15); push4(3, 7, 11, 15);
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    cyc();
    in_valid4 = 1'b0;
    check("basic_first_valid", int'(out_valid4), 1);
    check("basic_first_data",  int'(out_data4),  3);
    check("basic_busy",        int'(busy4),      1);
    check("basic_in_ready",    int'(in_ready4),  0);
    cyc(4);
    check("basic_end_valid",    int'(out_valid4), 0);
    check("basic_end_in_ready", int'(in_ready4),  1);
    check("basic_q_empty",      q4.size(),        0);

    // Backpressure on element 7
    push4(3, 7, 11, 15);
    in_valid4 = 1'b1;
    cyc();
    in_valid4 = 1'b0;
    cyc();
    out_ready4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_data",     int'(out_data4),  7);
      check("bp_idx",      int'(out_idx4),   1);
      check("bp_in_ready", int'(in_ready4),  0);
      check("bp_valid",    int'(out_valid4), 1);
      cyc();
    end
    check("bp_hold_after", int'(out_data4), 7);
    out_ready4 = 1'b1;
    cyc(3);
    check("bp_end_valid", int'(out_valid4), 0);
    check("bp_q_empty",   q4.size(),        0);

    // Back-to-back A then B, no bubble
    load4(1, 2, 3, 4); push4(1, 2, 3, 4); push4(5, 6, 7, 8);
    in_valid4 = 1'b1;
    cyc();
    load4(5, 6, 7, 8);
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", int'(out_valid4), 1);
      if (i == 0) check("b2b_in_ready_mid",  int'(in_ready4), 0);
      if (i == 3) check("b2b_in_ready_last", int'(in_ready4), 1);
      cyc();
      if (i == 3) in_valid4 = 1'b0;
    end
    check("b2b_end_valid", int'(out_valid4), 0);
    check("b2b_q_empty",   q4.size(),        0);

    // Input isolation: in_data changes after capture are ignored
    load4(3, 7, 11, 15); push4(3, 7, 11, 15);
    in_valid4 = 1'b1;
    cyc();
    in_valid4 = 1'b0;
    load4(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    cyc(4);
    check("iso_end_valid", int'(out_valid4), 0);
    check("iso_q_empty",   q4.size(),        0);

    // Reset after element 7
    load4(3, 7, 11, 15);
    q4.push_back('{data: 3, idx: 0, last: 1'b0});
    q4.push_back('{data: 7, idx: 1, last: 1'b0});
    in_valid4 = 1'b1;
    cyc();
    in_valid4 = 1'b0;
    cyc(2);
    rst4 = 1'b1;
    cyc();
    check("mid_rst_valid", int'(out_valid4), 0);
    check("mid_rst_idx",   int'(out_idx4),   0);
    check("mid_rst_data",  int'(out_data4),  0);
    check("mid_rst_busy",  int'(busy4),      0);
    check("mid_rst_q",     q4.size(),        0);
    rst4 = 1'b0;
    load4(9, 9, 9, 9); push4(9, 9, 9, 9);
    in_valid4 = 1'b1;
    cyc();
    in_valid4 = 1'b0;
    cyc(4);
    check("post_rst_end_valid", int'(out_valid4), 0);
    check("post_rst_q_empty",   q4.size(),        0);

    // N=1: 5 then 12 back-to-back
    rst1 = 1'b0;
    out_ready1 = 1'b1;
    in1[0] = 4'd5; in_valid1 = 1'b1;
    q1.push_back('{data: 5, idx: 0, last: 1'b1});
    cyc();
    in1[0] = 4'd12;
    q1.push_back('{data: 12, idx: 0, last: 1'b1});
    check("n1_first_valid", int'(out_valid1), 1);
    check("n1_first_data",  int'(out_data1),  5);
    check("n1_in_ready",    int'(in_ready1),  1);
    cyc();
    in_valid1 = 1'b0;
    check("n1_second_valid", int'(out_valid1), 1);
    check("n1_second_data",  int'(out_data1),  12);
    cyc();
    check("n1_end_valid", int'(out_valid1), 0);
    check("n1_end_busy",  int'(busy1),      0);
    check("n1_q_empty",   q1.size(),        0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
